// File: rtl/seg7_pkg.sv
// seg7_pkg -- shared definitions for the seven-segment scan controller.
//   NUM_DIGITS    : number of multiplexed digits
//   DIGIT_IDX_W   : width of the digit index
//   SEG_OFF       : all segments dark
//   scan_state_t  : scan FSM states (GAP = all digits off, DRIVE = one digit on)
//   msd_index()   : index of the most-significant nonzero nibble (0 for value 0)
package seg7_pkg;

  localparam int NUM_DIGITS  = 4;
  localparam int DIGIT_IDX_W = 2;

  localparam logic [6:0] SEG_OFF = 7'h00;

  typedef enum logic {
    ST_GAP   = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_t;

  // Digit 0 is always the answer for an all-zero value, so a blank display
  // still shows a single "0".
  function automatic logic [DIGIT_IDX_W-1:0] msd_index(input logic [4*NUM_DIGITS-1:0] value);
    logic [DIGIT_IDX_W-1:0] msd;
    msd = '0;
    for (int n = 1; n < NUM_DIGITS; n++) begin
      if (value[4*n +: 4] != 4'h0) msd = DIGIT_IDX_W'(n);
    end
    return msd;
  endfunction

endpackage

// File: rtl/Binary_to_7Segment.sv
// Binary_to_7Segment -- registered hex-to-seven-segment decoder (1 cycle latency).
//   i_Clk        : clock
//   i_Rst_L      : asynchronous active-low reset (clears the segment register)
//   i_Binary_Num : hex nibble to decode
//   o_Segment    : active-high segments, bit6 = A ... bit0 = G
module Binary_to_7Segment (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [3:0] i_Binary_Num,
  output logic [6:0] o_Segment
);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_Segment <= 7'h00;
    end else begin
      case (i_Binary_Num)
        4'h0: o_Segment <= 7'h7e;
        4'h1: o_Segment <= 7'h30;
        4'h2: o_Segment <= 7'h6d;
        4'h3: o_Segment <= 7'h79;
        4'h4: o_Segment <= 7'h33;
        4'h5: o_Segment <= 7'h5b;
        4'h6: o_Segment <= 7'h5f;
        4'h7: o_Segment <= 7'h70;
        4'h8: o_Segment <= 7'h7f;
        4'h9: o_Segment <= 7'h7b;
        4'hA: o_Segment <= 7'h77;
        4'hB: o_Segment <= 7'h1f;
        4'hC: o_Segment <= 7'h4e;
        4'hD: o_Segment <= 7'h3d;
        4'hE: o_Segment <= 7'h4f;
        default: o_Segment <= 7'h47;
      endcase
    end
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl -- four-digit multiplexed seven-segment scan controller
// with a staged, frame-aligned value update and optional leading-zero blanking.
//   i_Clk         : clock
//   i_Rst_L       : asynchronous active-low reset (deassertion synchronised)
//   i_En          : scan enable
//   i_Value       : four hex digits, digit n in [4n+3:4n]
//   i_Load        : one-cycle request to stage i_Value
//   i_Blank_Lz    : leading-zero blanking enable
//   o_Load_Ack    : one-cycle pulse when a staged value is committed
//   o_Pending     : a staged value is waiting for the frame boundary
//   o_Frame_Start : one-cycle pulse on entry to digit 0 DRIVE
//   o_Digit_En    : one-hot active-high digit enables
//   o_Segment     : active-high segments, bit6 = A ... bit0 = G
module seven_seg_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int CLKS_PER_DIGIT = 25000,
  parameter int CLKS_BLANK     = 250
) (
  input  logic        i_Clk,
  input  logic        i_Rst_L,
  input  logic        i_En,
  input  logic [15:0] i_Value,
  input  logic        i_Load,
  input  logic        i_Blank_Lz,
  output logic        o_Load_Ack,
  output logic        o_Pending,
  output logic        o_Frame_Start,
  output logic [3:0]  o_Digit_En,
  output logic [6:0]  o_Segment
);

  localparam logic [19:0] DRIVE_LAST = 20'(CLKS_PER_DIGIT - 1);
  localparam logic [19:0] GAP_LAST   = 20'(CLKS_BLANK - 1);
  localparam logic [DIGIT_IDX_W-1:0] LAST_DIGIT = DIGIT_IDX_W'(NUM_DIGITS - 1);

  logic [1:0]             rst_sync;
  logic                   rst_n;
  logic                   en_q;
  scan_state_t            state, state_next;
  logic [DIGIT_IDX_W-1:0] idx, idx_next;
  logic [19:0]            cnt, cnt_next;
  logic [15:0]            disp_val, stage_val;
  logic                   pending;
  logic                   last_cycle;
  logic                   commit;
  logic                   blanked;
  logic [3:0]             digit_nibble;
  logic [3:0]             digit_onehot;
  logic [6:0]             dec_seg;

  // Assert asynchronously, release two clocks after i_Rst_L rises.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  // Registering the enable gives the extra cycle between i_En rising and
  // the first GAP cycle of the scan.
  always_ff @(posedge i_Clk or negedge rst_n) begin
    if (!rst_n) en_q <= 1'b0;
    else        en_q <= i_En;
  end

  always_ff @(posedge i_Clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_GAP;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    cnt_next   = cnt + 20'd1;
    if (!en_q) begin
      state_next = ST_GAP;
      idx_next   = '0;
      cnt_next   = '0;
    end else if (state == ST_GAP) begin
      if (cnt == GAP_LAST) begin
        state_next = ST_DRIVE;
        cnt_next   = '0;
      end
    end else if (cnt == DRIVE_LAST) begin
      state_next = ST_GAP;
      idx_next   = idx + 1'b1;
      cnt_next   = '0;
    end
  end

  // The display register only changes at the frame boundary, or at once
  // while the scan is idle, so one frame never mixes two values.
  assign last_cycle = en_q && (state == ST_DRIVE) && (idx == LAST_DIGIT) && (cnt == DRIVE_LAST);
  assign commit     = !en_q || last_cycle;

  // A load arriving in the commit cycle bypasses staging altogether.
  always_ff @(posedge i_Clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_val  <= 16'h0000;
      stage_val <= 16'h0000;
      pending   <= 1'b0;
    end else if (commit) begin
      if (i_Load) begin
        disp_val  <= i_Value;
        stage_val <= i_Value;
      end else if (pending) begin
        disp_val  <= stage_val;
      end
      pending <= 1'b0;
    end else if (i_Load) begin
      stage_val <= i_Value;
      pending   <= 1'b1;
    end
  end

  // The index advances on entry to GAP, so the decoder's register has
  // settled on the new digit before DRIVE begins.
  assign digit_nibble = disp_val[4*idx +: 4];

  Binary_to_7Segment u_decoder (
    .i_Clk        (i_Clk),
    .i_Rst_L      (rst_n),
    .i_Binary_Num (digit_nibble),
    .o_Segment    (dec_seg)
  );

  assign blanked       = i_Blank_Lz && (idx > msd_index(disp_val));
  assign digit_onehot  = 4'b0001 << idx;
  assign o_Digit_En    = (en_q && (state == ST_DRIVE) && !blanked) ? digit_onehot : 4'b0000;
  assign o_Segment     = (|o_Digit_En) ? dec_seg : SEG_OFF;
  assign o_Frame_Start = en_q && (state == ST_DRIVE) && (idx == '0) && (cnt == '0);
  assign o_Pending     = pending;
  assign o_Load_Ack    = rst_n && commit && (pending || i_Load);

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb_seven_seg_scan_ctrl -- self-checking bench for seven_seg_scan_ctrl with
// CLKS_PER_DIGIT=4, CLKS_BLANK=2 (frame = 24 clocks).
module tb_seven_seg_scan_ctrl;

  localparam int P     = 4;
  localparam int B     = 2;
  localparam int SLOT  = P + B;
  localparam int FRAME = 4 * SLOT;

  logic        i_Clk = 1'b0;
  logic        i_Rst_L;
  logic        i_En;
  logic [15:0] i_Value;
  logic        i_Load;
  logic        i_Blank_Lz;
  logic        o_Load_Ack;
  logic        o_Pending;
  logic        o_Frame_Start;
  logic [3:0]  o_Digit_En;
  logic [6:0]  o_Segment;

  int tests_run    = 0;
  int tests_failed = 0;
  int ack_seen     = 0;

  seven_seg_scan_ctrl #(.CLKS_PER_DIGIT(P), .CLKS_BLANK(B)) dut (
    .i_Clk         (i_Clk),
    .i_Rst_L       (i_Rst_L),
    .i_En          (i_En),
    .i_Value       (i_Value),
    .i_Load        (i_Load),
    .i_Blank_Lz    (i_Blank_Lz),
    .o_Load_Ack    (o_Load_Ack),
    .o_Pending     (o_Pending),
    .o_Frame_Start (o_Frame_Start),
    .o_Digit_En    (o_Digit_En),
    .o_Segment     (o_Segment)
  );

  always #5 i_Clk = ~i_Clk;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'h7e;  4'h1: return 7'h30;  4'h2: return 7'h6d;  4'h3: return 7'h79;
      4'h4: return 7'h33;  4'h5: return 7'h5b;  4'h6: return 7'h5f;  4'h7: return 7'h70;
      4'h8: return 7'h7f;  4'h9: return 7'h7b;  4'hA: return 7'h77;  4'hB: return 7'h1f;
      4'hC: return 7'h4e;  4'hD: return 7'h3d;  4'hE: return 7'h4f;  default: return 7'h47;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [263:0] actual, input logic [263:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Reference model: scan position counted in clocks since the scan became
  // active; digit = pos / SLOT, and the first B clocks of each slot are dark.
  int          m_sync = 0;
  bit          m_active = 0;
  int          m_pos = 0;
  logic [15:0] m_disp = 16'h0;
  logic [15:0] m_stage = 16'h0;
  bit          m_pend = 0;
  bit          m_in_reset, m_commit, m_drive, m_blanked;
  int          m_digit, m_off, m_msd;
  logic [3:0]  m_den;
  logic [6:0]  m_seg;
  logic [13:0] m_exp;

  always @(negedge i_Clk) begin
    if (!i_Rst_L) begin
      m_sync = 0; m_active = 0; m_pos = 0; m_disp = 16'h0; m_stage = 16'h0; m_pend = 0;
    end
    m_in_reset = (m_sync < 2);
    m_digit    = m_pos / SLOT;
    m_off      = m_pos % SLOT;
    m_drive    = m_active && (m_off >= B);
    m_commit   = !m_in_reset && (!m_active || (m_pos == FRAME - 1));
    m_msd      = (m_disp > 16'h0FFF) ? 3 : (m_disp > 16'h00FF) ? 2 : (m_disp > 16'h000F) ? 1 : 0;
    m_blanked  = i_Blank_Lz && (m_digit > m_msd);
    m_den      = (m_drive && !m_blanked) ? 4'(1 << m_digit) : 4'b0000;
    m_seg      = (m_den != 4'b0000) ? seg_of(4'((m_disp >> (4 * m_digit)) & 16'hF)) : 7'h00;
    m_exp      = {m_commit && (m_pend || i_Load), m_pend, m_active && (m_pos == B), m_den, m_seg};
    checkOutput($sformatf("model @%0t", $time),
                {o_Load_Ack, o_Pending, o_Frame_Start, o_Digit_En, o_Segment}, m_exp);
    if (i_Rst_L) begin
      if (!m_in_reset) begin
        if (m_commit) begin
          if (i_Load)      m_disp = i_Value;
          else if (m_pend) m_disp = m_stage;
          m_pend = 0;
        end else if (i_Load) begin
          m_stage = i_Value;
          m_pend  = 1;
        end
        m_pos    = m_active ? (m_pos + 1) % FRAME : 0;
        m_active = i_En;
      end
      if (m_sync < 2) m_sync++;
    end
  end

  task automatic applyStimulus(input logic rst_l, input logic en, input logic load,
                               input logic [15:0] value, input logic blz);
    @(posedge i_Clk);
    #1;
    i_Rst_L    = rst_l;
    i_En       = en;
    i_Load     = load;
    i_Value    = value;
    i_Blank_Lz = blz;
  endtask

  task automatic step(input logic load, input logic [15:0] value);
    applyStimulus(i_Rst_L, i_En, load, value, i_Blank_Lz);
    @(negedge i_Clk);
    if (o_Load_Ack) ack_seen++;
  endtask

  task automatic waitFrameStart(output int n);
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      step(1'b0, i_Value);
      if (o_Frame_Start) begin
        n = i;
        break;
      end
    end
    if (n < 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL frame_start_timeout: got none in 60 cycles, expected a pulse");
    end
  endtask

  task automatic waitAck();
    for (int i = 0; i < 40 && ack_seen == 0; i++) step(1'b0, i_Value);
    if (ack_seen == 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL ack_timeout: got no ack in 40 cycles, expected one");
    end
  endtask

  // Starts on a frame-start cycle and covers one full frame.
  task automatic captureFrame(output logic [3:0] mask, output logic [27:0] segs);
    mask = 4'b0000;
    segs = 28'h0;
    for (int k = 0; k < FRAME; k++) begin
      if (k > 0) step(1'b0, i_Value);
      for (int d = 0; d < 4; d++) begin
        if (o_Digit_En[d]) begin
          mask[d]         = 1'b1;
          segs[7*d +: 7]  = o_Segment;
        end
      end
    end
  endtask

  typedef struct packed {
    logic [15:0] value;
    logic        blz;
    logic [3:0]  mask;
    logic [27:0] segs;
  } vec_t;

  vec_t         vecs [7];
  int           n;
  logic [3:0]   mask;
  logic [27:0]  segs;
  logic [263:0] seq_act, seq_exp;
  logic [3:0]   exp_den;
  logic         r_rst, r_en, r_load, r_blz;

  initial begin
    vecs[0] = '{16'h1A2F, 1'b0, 4'b1111, {7'h30, 7'h77, 7'h6d, 7'h47}};
    vecs[1] = '{16'h00B0, 1'b1, 4'b0011, {7'h00, 7'h00, 7'h1f, 7'h7e}};
    vecs[2] = '{16'h0000, 1'b1, 4'b0001, {7'h00, 7'h00, 7'h00, 7'h7e}};
    vecs[3] = '{16'h0000, 1'b0, 4'b1111, {7'h7e, 7'h7e, 7'h7e, 7'h7e}};
    vecs[4] = '{16'h0507, 1'b1, 4'b0111, {7'h00, 7'h5b, 7'h7e, 7'h70}};
    vecs[5] = '{16'hC3E9, 1'b1, 4'b1111, {7'h4e, 7'h79, 7'h4f, 7'h7b}};
    vecs[6] = '{16'h8000, 1'b1, 4'b1111, {7'h7f, 7'h7e, 7'h7e, 7'h7e}};

    i_Rst_L = 1'b0; i_En = 1'b0; i_Load = 1'b0; i_Value = 16'h0; i_Blank_Lz = 1'b0;

    applyStimulus(1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b1);
    @(negedge i_Clk);
    checkOutput("reset_outputs", {o_Load_Ack, o_Pending, o_Frame_Start, o_Digit_En, o_Segment}, 14'h0);

    // Free-running scan of the reset value 0000.
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    @(negedge i_Clk);
    waitFrameStart(n);
    seq_act = '0;
    seq_exp = '0;
    for (int k = 0; k < FRAME; k++) begin
      if (k > 0) step(1'b0, i_Value);
      seq_act[11*k +: 11] = {o_Digit_En, o_Segment};
      exp_den = ((k % SLOT) < P) ? 4'(1 << (k / SLOT)) : 4'b0000;
      seq_exp[11*k +: 11] = {exp_den, (exp_den != 4'b0000) ? 7'h7e : 7'h00};
    end
    checkOutput("scan_sequence", seq_act, seq_exp);
    waitFrameStart(n);
    checkOutput("gap_after_digit3", 32'(n), 32'd1);
    waitFrameStart(n);
    checkOutput("frame_period", 32'(n), 32'(FRAME));

    // Enable rising: first digit-0 DRIVE B+1 clocks later.
    applyStimulus(1'b1, 1'b0, 1'b0, i_Value, 1'b0);
    repeat (5) step(1'b0, i_Value);
    applyStimulus(1'b1, 1'b1, 1'b0, i_Value, 1'b0);
    @(negedge i_Clk);
    checkOutput("en_rise_no_drive", {28'h0, o_Digit_En}, 32'h0);
    waitFrameStart(n);
    checkOutput("en_rise_latency", 32'(n), 32'(B + 1));

    // Table: mid-frame load, frame-aligned commit, next-frame contents.
    for (int v = 0; v < 7; v++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, i_Value, vecs[v].blz);
      @(negedge i_Clk);
      waitFrameStart(n);
      repeat (4) step(1'b0, i_Value);
      ack_seen = 0;
      step(1'b1, vecs[v].value);
      step(1'b0, vecs[v].value);
      checkOutput($sformatf("pending_%0d", v), {31'h0, o_Pending}, 32'h1);
      waitAck();
      waitFrameStart(n);
      captureFrame(mask, segs);
      checkOutput($sformatf("mask_%0d", v), {28'h0, mask}, {28'h0, vecs[v].mask});
      checkOutput($sformatf("segs_%0d", v), {4'h0, segs}, {4'h0, vecs[v].segs});
      checkOutput($sformatf("acks_%0d", v), 32'(ack_seen), 32'd1);
    end

    // Two loads within one frame: one ack, latest value shown.
    applyStimulus(1'b1, 1'b1, 1'b0, i_Value, 1'b0);
    @(negedge i_Clk);
    waitFrameStart(n);
    ack_seen = 0;
    step(1'b1, 16'h0011);
    repeat (3) step(1'b0, 16'h0011);
    step(1'b1, 16'h0022);
    waitAck();
    waitFrameStart(n);
    captureFrame(mask, segs);
    checkOutput("double_load_segs", {4'h0, segs}, {4'h0, 7'h7e, 7'h7e, 7'h6d, 7'h6d});
    checkOutput("double_load_acks", 32'(ack_seen), 32'd1);

    // Load exactly in the commit cycle (last DRIVE clock of digit 3).
    waitFrameStart(n);
    repeat (FRAME - B - 2) step(1'b0, i_Value);
    step(1'b1, 16'h4444);
    checkOutput("commit_cycle_ack", {o_Load_Ack, o_Pending}, 2'b10);
    ack_seen = 0;
    waitFrameStart(n);
    captureFrame(mask, segs);
    checkOutput("commit_cycle_segs", {4'h0, segs}, {4'h0, 7'h33, 7'h33, 7'h33, 7'h33});
    checkOutput("commit_cycle_no_more_acks", 32'(ack_seen), 32'd0);

    // Reset during DRIVE digit 2 with a load pending.
    waitFrameStart(n);
    step(1'b1, 16'h9999);
    repeat (2 * SLOT - 1) step(1'b0, i_Value);
    checkOutput("drive_digit2", {28'h0, o_Digit_En}, 32'h4);
    applyStimulus(1'b0, 1'b1, 1'b0, i_Value, 1'b0);
    #1;
    checkOutput("reset_immediate", {o_Load_Ack, o_Pending, o_Frame_Start, o_Digit_En, o_Segment}, 14'h0);
    ack_seen = 0;
    @(negedge i_Clk);
    repeat (2) step(1'b0, i_Value);
    applyStimulus(1'b1, 1'b1, 1'b0, i_Value, 1'b0);
    @(negedge i_Clk);
    waitFrameStart(n);
    checkOutput("reset_no_pending", {31'h0, o_Pending}, 32'h0);
    captureFrame(mask, segs);
    checkOutput("reset_restart_segs", {mask, segs}, {4'b1111, 7'h7e, 7'h7e, 7'h7e, 7'h7e});
    checkOutput("reset_no_ack", 32'(ack_seen), 32'd0);

    // Randomised traffic, checked every cycle by the reference model.
    r_en  = 1'b1;
    r_blz = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      r_rst  = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 149) == 0) r_en  = ~r_en;
      if ($urandom_range(0, 199) == 0) r_blz = ~r_blz;
      r_load = ($urandom_range(0, 7) == 0);
      applyStimulus(r_rst, r_en, r_load, 16'($urandom), r_blz);
    end
    @(negedge i_Clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
